reg_bank_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a bank of `DEPTH` chip-enable-gated registers of width `WIDTH`. `NREQ` requesters each present an address/data write request; the block grants one at a time. It drives the shared data bus `REG_D` and the one-hot per-register enables `REG_CE`, then returns a one-cycle `ACK` to the winner. It sits between control-path masters and the register bank, and is the only agent permitted to assert the bank's CE lines.

---
 rtl/reg_bank_arbiter_pkg.sv | 30 +++
 rtl/rr_picker.sv | 20 ++
 rtl/reg_bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and the round-robin search helper for reg_bank_arbiter and rr_picker.
package reg_bank_arbiter_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned MAX_IW   = 3;

  typedef enum logic {IDLE, WRITE} arb_state_t;

  // First set bit of req at or after ptr, wrapping modulo nreq (nreq <= MAX_NREQ).
  function automatic logic [MAX_IW-1:0] rr_index(input logic [MAX_NREQ-1:0] req,
                                                 input logic [MAX_IW-1:0]   ptr,
                                                 input int unsigned         nreq);
    logic [MAX_IW-1:0] idx;
    logic              found;
    logic [31:0]       k;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq && !found) begin
        k = (32'(ptr) + i) % nreq;
        if (req[k[MAX_IW-1:0]]) begin
          idx   = k[MAX_IW-1:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority picker: first requester at or after ptr wins.
module rr_picker
  import reg_bank_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [MAX_NREQ-1:0] req_pad;

  assign req_pad = MAX_NREQ'(req);
  assign idx     = IW'(rr_index(req_pad, MAX_IW'(ptr), NREQ));
  assign valid   = |req;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter/sequencer for a CE-gated register bank.
// Optional grant hold via `define REG_ARB_LOCK_EN.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*AW-1:0]    ADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  input  logic [NREQ-1:0]       LOCK,
  output logic [NREQ-1:0]       ACK,
  output logic                  ERR,
  output logic [IW-1:0]         GNT_ID,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      REG_D,
  output logic [DEPTH-1:0]      REG_CE
);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [DEPTH-1:0] ce_q, ce_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             err_q, err_d, busy_q, busy_d;

  logic [NREQ-1:0]  pick_req;
  logic [IW-1:0]    pick_ptr, pick_idx;
  logic             pick_vld;
  logic [AW-1:0]    win_addr;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    return (p == IW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef REG_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_lock;
  assign unused_lock = ^LOCK;
`endif

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // While locked, only the holder may win; once it lets go, search resumes just past it.
  always_comb begin
    pick_req = REQ;
    pick_ptr = ptr_q;
`ifdef REG_ARB_LOCK_EN
    if (lock_q) begin
      if (REQ[gnt_q]) pick_req = NREQ'(1) << gnt_q;
      else            pick_ptr = inc_ptr(gnt_q);
    end
`endif
    win_addr = ADDR[pick_idx*AW +: AW];
  end

  // Outputs are computed here and registered, so they appear during the WRITE cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    ce_d    = '0;
    d_d     = d_q;
    err_d   = 1'b0;
    busy_d  = 1'b0;
`ifdef REG_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef REG_ARB_LOCK_EN
        if (lock_q && !REQ[gnt_q]) begin
          lock_d = 1'b0;
          ptr_d  = inc_ptr(gnt_q);
        end
`endif
        if (pick_vld) begin
          state_d = WRITE;
          gnt_d   = pick_idx;
          d_d     = WDATA[pick_idx*WIDTH +: WIDTH];
          ack_d   = NREQ'(1) << pick_idx;
          busy_d  = 1'b1;
          if (32'(win_addr) < DEPTH) ce_d = DEPTH'(1) << win_addr;
          else                       err_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
        if (LOCK[gnt_q]) begin
          lock_d = 1'b1;
        end else begin
          lock_d = 1'b0;
          ptr_d  = inc_ptr(gnt_q);
        end
`else
        ptr_d = inc_ptr(gnt_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      ce_q    <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ce_q    <= ce_d;
      d_q     <= d_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef REG_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign ACK    = ack_q;
  assign ERR    = err_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = busy_q;
  assign REG_D  = d_q;
  assign REG_CE = ce_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: a DEPTH=4 instance plus a DEPTH=3 instance for ERR.
module tb_reg_bank_arbiter;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] ce;
    logic [7:0] d;
    logic       err;
    logic [1:0] gnt;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req, req2, lock;
  logic [7:0]  addr;
  logic [31:0] wdata;

  logic [3:0]  ack1, ack2, ce1;
  logic [2:0]  ce2;
  logic        err1, err2, busy1, busy2;
  logic [1:0]  gnt1, gnt2;
  logic [7:0]  d1, d2;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .ADDR(addr), .WDATA(wdata), .LOCK(lock),
    .ACK(ack1), .ERR(err1), .GNT_ID(gnt1), .BUSY(busy1), .REG_D(d1), .REG_CE(ce1)
  );

  reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ(req2), .ADDR(addr), .WDATA(wdata), .LOCK(lock),
    .ACK(ack2), .ERR(err2), .GNT_ID(gnt2), .BUSY(busy2), .REG_D(d2), .REG_CE(ce2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int who, input logic [3:0] ce, input logic [7:0] d,
                              input logic err, input int c);
    exp_t e;
    e.ack = 4'(1) << who;
    e.ce  = ce;
    e.d   = d;
    e.err = err;
    e.gnt = 2'(who);
    e.cyc = c;
    return e;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rq(input int i, input logic [1:0] a, input logic [7:0] d);
    addr[i*2 +: 2]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack1 != '0) begin
        if (q1.size() == 0) check("dut_spurious_ack", 32'(ack1), 0);
        else begin
          m1 = q1.pop_front();
          check("dut_ack",   32'(ack1),  32'(m1.ack));
          check("dut_ce",    32'(ce1),   32'(m1.ce));
          check("dut_d",     32'(d1),    32'(m1.d));
          check("dut_err",   32'(err1),  32'(m1.err));
          check("dut_gnt",   32'(gnt1),  32'(m1.gnt));
          check("dut_busy",  32'(busy1), 1);
          check("dut_cycle", cyc,        m1.cyc);
        end
      end else check("dut_ce_idle", 32'(ce1), 0);

      if (ack2 != '0) begin
        if (q2.size() == 0) check("dut3_spurious_ack", 32'(ack2), 0);
        else begin
          m2 = q2.pop_front();
          check("dut3_ack",   32'(ack2), 32'(m2.ack));
          check("dut3_ce",    32'(ce2),  32'(m2.ce));
          check("dut3_d",     32'(d2),   32'(m2.d));
          check("dut3_err",   32'(err2), 32'(m2.err));
          check("dut3_gnt",   32'(gnt2), 32'(m2.gnt));
          check("dut3_cycle", cyc,       m2.cyc);
        end
      end else begin
        check("dut3_ce_idle",  32'(ce2),  0);
        check("dut3_err_idle", 32'(err2), 0);
      end
    end
  end

  initial begin : stim
    int c;
    logic [3:0] prev_ack, raise;
    rst = 1'b1; req = '0; req2 = '0; lock = '0; addr = '0; wdata = '0;
    step(3);
    check("rst_ack",  32'(ack1),  0);
    check("rst_err",  32'(err1),  0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_ce",   32'(ce1),   0);
    check("rst_d",    32'(d1),    0);
    check("rst_gnt",  32'(gnt1),  0);
    rst = 1'b0;
    mon_en = 1'b1;

    // single request
    c = cyc;
    set_rq(0, 2'd2, 8'hA5);
    req = 4'b0001;
    q1.push_back(mk(0, 4'b0100, 8'hA5, 1'b0, c + 1));
    step();
    req = '0;
    step(3);
    check("hold_d",    32'(d1),    32'hA5);
    check("idle_busy", 32'(busy1), 0);

    // fairness under full load
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 2'(i), 8'(8'h10 + i));
    c = cyc;
    req = 4'b1111;
    q1.push_back(mk(0, 4'b0001, 8'h10, 1'b0, c + 1));
    q1.push_back(mk(1, 4'b0010, 8'h11, 1'b0, c + 3));
    q1.push_back(mk(2, 4'b0100, 8'h12, 1'b0, c + 5));
    q1.push_back(mk(3, 4'b1000, 8'h13, 1'b0, c + 7));
    q1.push_back(mk(0, 4'b0001, 8'h10, 1'b0, c + 9));
    prev_ack = '0;
    raise = '0;
    for (int k = 0; k < 9; k++) begin
      step();
      req = req | raise;
      req = req & ~prev_ack;
      raise = prev_ack;
      prev_ack = ack1;
    end
    req = '0;
    step(3);

    // wrap-around: grant 2 moves ptr to 3, then 1001 serves 3 before 0
    set_rq(2, 2'd1, 8'h22);
    c = cyc;
    req = 4'b0100;
    q1.push_back(mk(2, 4'b0010, 8'h22, 1'b0, c + 1));
    step();
    req = '0;
    step(2);
    set_rq(3, 2'd0, 8'h33);
    set_rq(0, 2'd3, 8'h30);
    c = cyc;
    req = 4'b1001;
    q1.push_back(mk(3, 4'b0001, 8'h33, 1'b0, c + 1));
    q1.push_back(mk(0, 4'b1000, 8'h30, 1'b0, c + 3));
    step();
    req = 4'b0001;
    step(2);
    req = '0;
    step(3);

    // reset on the grant edge: no write, ptr back to 0
    set_rq(1, 2'd1, 8'h77);
    req = 4'b0010;
    rst = 1'b1;
    step();
    check("rstw_ack",  32'(ack1),  0);
    check("rstw_ce",   32'(ce1),   0);
    check("rstw_busy", 32'(busy1), 0);
    check("rstw_gnt",  32'(gnt1),  0);
    rst = 1'b0;
    set_rq(0, 2'd2, 8'h70);
    c = cyc;
    req = 4'b0011;
    q1.push_back(mk(0, 4'b0100, 8'h70, 1'b0, c + 1));
    q1.push_back(mk(1, 4'b0010, 8'h77, 1'b0, c + 3));
    step();
    req = 4'b0010;
    step(2);
    req = '0;
    step(3);

    // out-of-range and last in-range address on the DEPTH=3 instance
    set_rq(0, 2'd3, 8'h3C);
    c = cyc;
    req2 = 4'b0001;
    q2.push_back(mk(0, 4'b0000, 8'h3C, 1'b1, c + 1));
    step();
    req2 = '0;
    step(2);
    set_rq(1, 2'd2, 8'h5A);
    c = cyc;
    req2 = 4'b0010;
    q2.push_back(mk(1, 4'b0100, 8'h5A, 1'b0, c + 1));
    step();
    req2 = '0;
    step(3);

`ifdef REG_ARB_LOCK_EN
    do_reset();
    set_rq(0, 2'd0, 8'h40);
    set_rq(1, 2'd1, 8'h41);
    set_rq(2, 2'd2, 8'h42);
    c = cyc;
    req = 4'b0111;
    lock = 4'b0010;
    q1.push_back(mk(0, 4'b0001, 8'h40, 1'b0, c + 1));
    q1.push_back(mk(1, 4'b0010, 8'h41, 1'b0, c + 3));
    q1.push_back(mk(1, 4'b0010, 8'h41, 1'b0, c + 5));
    q1.push_back(mk(1, 4'b0010, 8'h41, 1'b0, c + 7));
    q1.push_back(mk(2, 4'b0100, 8'h42, 1'b0, c + 9));
    step();
    req = 4'b0110;
    step(6);
    lock = '0;
    step(2);
    req = '0;
    step(3);
`endif

    step(2);
    check("q_dut_empty",  32'(q1.size()), 0);
    check("q_dut3_empty", 32'(q2.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
